// File: rtl/la_readout.sv
// Streams a decimated window of the LA capture RAM onto a valid/ready sample stream.
// Latency: rd_addr one cycle after start, first sample 2+RD_LAT cycles after start, then gapless.
// Backpressure: reads are issued only against free FIFO credit, so at most RD_LAT+2 samples are outstanding.

// Small FIFO whose head sits in an output register; an empty FIFO loads the head directly.
// Latency: one cycle from push to head_vld.
// Backpressure: none internally; the caller must never push into a full FIFO.
module la_readout_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic          head_vld,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] cnt
);
  localparam int QD = DEPTH - 1;
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;

  logic [W-1:0]  mem [QD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_cnt;
  logic          load_head, q_pop, bypass, q_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign load_head = !head_vld || pop;
  assign q_pop     = load_head && (q_cnt != '0);
  assign bypass    = load_head && (q_cnt == '0) && push_vld;
  assign q_push    = push_vld && !bypass;
  assign cnt       = q_cnt + CW'(head_vld);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_cnt    <= '0;
      head_vld <= 1'b0;
      head_dat <= '0;
    end else begin
      if (q_push) wr_ptr <= ptr_inc(wr_ptr);
      if (q_pop)  rd_ptr <= ptr_inc(rd_ptr);
      q_cnt <= q_cnt + CW'(q_push) - CW'(q_pop);
      if (load_head) begin
        head_vld <= q_pop || bypass;
        if (q_pop)       head_dat <= mem[rd_ptr];
        else if (bypass) head_dat <= push_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module la_readout #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [2:0]        step,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q, len_q, issued, captured;
  logic [2:0]        step_q;
  logic [RD_LAT:0]   tag_sr;
  logic [CW-1:0]     inflight, fifo_cnt;
  logic [DATA_W:0]   head_dat;
  logic              pop, accept, issue, done_nxt, cap_last;

  // Bit 0 is aligned with rd_addr, bit RD_LAT with the matching rd_data.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + CW'(tag_sr[i]);
  end

  assign pop      = out_valid && out_ready;
  assign cap_last = (captured == len_q - ADDR_W'(1));
  assign busy     = (state != IDLE);
  assign out_data = head_dat[DATA_W-1:0];
  assign out_last = out_valid && head_dat[DATA_W];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_nxt = 1'b1;
          end else begin
            accept    = 1'b1;
            issue     = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (issued == len_q) state_nxt = DRAIN;
        // A pop this cycle frees a slot in time for the new read's data.
        else issue = (fifo_cnt + inflight) < (CW'(DEPTH) + CW'(pop));
      end
      default: ;
    endcase
    if (state != IDLE && pop && out_last) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_addr  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      step_q   <= '0;
      issued   <= '0;
      captured <= '0;
      tag_sr   <= '0;
      done     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= done_nxt;
      tag_sr <= {tag_sr[RD_LAT-1:0], issue};
      if (accept) begin
        len_q    <= length;
        step_q   <= step;
        issued   <= ADDR_W'(1);
        captured <= '0;
        rd_addr  <= base_addr;
        addr_q   <= base_addr + (ADDR_W'(1) << step);
      end else begin
        if (issue) begin
          rd_addr <= addr_q;
          addr_q  <= addr_q + (ADDR_W'(1) << step_q);
          issued  <= issued + ADDR_W'(1);
        end
        if (tag_sr[RD_LAT]) captured <= captured + ADDR_W'(1);
      end
    end
  end

  la_readout_fifo #(
    .W    (DATA_W + 1),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk     (clk_50M),
    .rst     (rst),
    .push_vld(tag_sr[RD_LAT]),
    .push_dat({cap_last, rd_data}),
    .pop     (pop),
    .head_vld(out_valid),
    .head_dat(head_dat),
    .cnt     (fifo_cnt)
  );
endmodule

// File: doc/la_readout.md
# la_readout

Streams a window of captured samples out of the logic-analyzer capture RAM for display or host transfer. It sits directly downstream of the LA capture RAM, driving its `rd_addr` and consuming `rd_data` on the read clock. Given a base address, sample count and power-of-two decimation stride, it issues RAM reads, absorbs the RAM read latency in a small credit-controlled FIFO, and presents samples on a valid/ready stream with an end-of-window marker.

## Interface
- `ADDR_W`, 17, RAM address width (128K-sample buffer)
- `DATA_W`, 8, sample width (8 PMOD channels)
- `RD_LAT`, 1, RAM read latency in cycles (legal 1..3); internal FIFO depth = RD_LAT+2

- `clk_50M`  in  1  sole clock; also drives the RAM `rd_clk`
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  ADDR_W  first RAM address of the window
- `length`  in  ADDR_W  number of samples to emit (0 is legal)
- `step`  in  3  decimation; address stride = 1<<step (1..128)
- `rd_addr`  out  ADDR_W  RAM read address, registered
- `rd_data`  in  DATA_W  RAM read data, valid RD_LAT cycles after `rd_addr`
- `out_data`  out  DATA_W  sample
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`
- `out_last`  out  1  high with the final sample of the window
- `busy`  out  1  high from start acceptance until done
- `done`  out  1  one-cycle pulse when the window is fully delivered

## Operation
- FSM states IDLE, RUN, DRAIN.
- IDLE: on `start`, latch `base_addr`, `length`, `step`. If length==0, pulse `done` next cycle and stay in IDLE, with `busy` never asserting. Otherwise go to RUN with `busy`=1.
- RUN: issue one read per cycle while issued<length and (fifo_count + inflight) < RD_LAT+2.
  - Issue = drive `rd_addr` to the current address, then address += 1<<step.
  - Address arithmetic is modulo 2^ADDR_W, so the window wraps through 0 (circular capture buffer).
  - When issued==length, go to DRAIN.
- In-flight tracking: an RD_LAT-deep valid shift register. When a tagged slot exits, capture `rd_data` into the FIFO. Credit control guarantees the FIFO never overflows.
- FIFO output is registered (not fall-through). `out_data`/`out_valid` come from the FIFO head. `out_last` is high when the head sample is the length-th sample.
- DRAIN: continue popping. When inflight==0, the FIFO is empty and the last handshake is done, pulse `done`, clear `busy`, and return to IDLE.
- `start` while `busy` is ignored. `base_addr`/`length`/`step` changes during RUN have no effect.
- Counters are ADDR_W bits wide, so length up to 2^ADDR_W−1.

## Timing
- Reset values: `rd_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, FSM=IDLE, FIFO empty, inflight cleared.
- `rst` mid-run takes effect immediately (async). In-flight reads are discarded and no `done` pulse is produced. The next `start` after release runs normally.
- Cycle 0: `start` is sampled. Cycle 1: `busy`=1 and `rd_addr`=base.
- First `out_valid` appears at cycle 2+RD_LAT.
- With `out_ready` held high, the block sustains one sample per cycle, gapless.
- `out_data`, `out_valid` and `out_last` hold stable while `out_valid & !out_ready`.
- With `out_ready` low, issuing stops after at most RD_LAT+2 outstanding samples.
- `done` asserts in the cycle after the handshake of the `out_last` sample. `busy` falls in that same cycle.
- For length==0, `done` asserts at cycle 1.

## Test plan
- **Linear window.** RAM[a] = a[7:0]; base=0, length=4, step=0, out_ready=1.
  - Expect out_data 00,01,02,03 on consecutive cycles starting at cycle 2+RD_LAT.
  - `out_last` high only with 03; `done` pulses one cycle later.
- **Wrap-around.** base=0x1FFFE, length=4, step=0.
  - Expect rd_addr 1FFFE,1FFFF,00000,00001 and data FE,FF,00,01.
- **Decimation.** base=0x10, length=3, step=3.
  - Expect rd_addr 0x10,0x18,0x20 and data 10,18,20.
- **Backpressure.** length=16, step=0; out_ready low for cycles 3–12, then toggling every cycle.
  - All 16 samples delivered in order with no loss or duplication.
  - Outputs stable while stalled; outstanding reads never exceed RD_LAT+2.
- **Degenerate requests.** length=0 → `done` at cycle 1, no `out_valid`, `busy` stays 0.
  - `start` pulsed during a busy run → ignored; the current window completes unchanged.
- **Reset mid-run.** Assert `rst` halfway through a length=100 window.
  - All outputs are 0 the same cycle, and no `done` pulse.
  - After release, a new `start` with base=0x20, length=2 yields 20,21.
- Repeat all scenarios with RD_LAT=1 and RD_LAT=3.
